// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - Simon pattern playback: fetch color, light LED for ON interval, blank for GAP
module sequence_player #(
  parameter int MAX_LEN    = 32,
  parameter int IDX_W      = 5,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000,
  parameter int CNT_W      = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W:0]   length,
  input  logic [1:0]       speed,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [1:0]       rd_data,
  output logic [3:0]       led,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_ON    = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IDX_W:0]   LEN_MAX  = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0]   LEN_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_BASE  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0] GAP_BASE = CNT_W'(GAP_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W:0]   len_q;
  logic [IDX_W:0]   len_in;
  logic [CNT_W-1:0] on_dur;
  logic [CNT_W-1:0] gap_dur;
  logic [CNT_W-1:0] on_in;
  logic [CNT_W-1:0] gap_in;
  logic [CNT_W-1:0] on_shift;
  logic [CNT_W-1:0] gap_shift;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       color_q;
  logic             cnt_zero;
  logic             last_entry;

  // Values that get latched on an accepted start: clamped length and speed-scaled durations
  always_comb begin
    len_in    = (length > LEN_MAX) ? LEN_MAX : length;
    on_shift  = ON_BASE >> speed;
    gap_shift = GAP_BASE >> speed;
    on_in     = (on_shift == '0) ? CNT_ONE : on_shift;
    gap_in    = (gap_shift == '0) ? CNT_ONE : gap_shift;
  end

  assign cnt_zero   = (cnt == '0);
  assign last_entry = ({1'b0, idx} == (len_q - LEN_ONE));
  assign rd_addr    = idx;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition, including a start in IDLE
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = (len_in != '0) ? S_FETCH : S_DONE;
        S_FETCH: state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_ON;
        S_ON:    if (cnt_zero) state_nxt = S_GAP;
        S_GAP:   if (cnt_zero) state_nxt = last_entry ? S_DONE : S_FETCH;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: run parameters, entry index, interval counter and captured color
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      on_dur  <= '0;
      gap_dur <= '0;
      idx     <= '0;
      cnt     <= '0;
      color_q <= '0;
    end else if (abort) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q   <= len_in;
            on_dur  <= on_in;
            gap_dur <= gap_in;
            if (len_in != '0) idx <= '0;
          end
        end
        S_LOAD: begin
          color_q <= rd_data;
          cnt     <= on_dur - CNT_ONE;
        end
        S_ON: begin
          cnt <= cnt_zero ? (gap_dur - CNT_ONE) : (cnt - CNT_ONE);
        end
        S_GAP: begin
          if (cnt_zero) begin
            if (!last_entry) idx <= idx + IDX_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only, so reset clears them immediately
  always_comb begin
    led  = 4'b0000;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:  ;
      S_ON:    begin busy = 1'b1; led = 4'b0001 << color_q; end
      S_DONE:  begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Playback controller for the Simon game's stored color pattern. On a start pulse it reads the pattern memory one entry at a time and lights the corresponding LED for an ON interval, then blanks it for a GAP interval. It repeats this until `length` entries have been shown, then pulses `done`. Interval lengths derive from base cycle counts scaled by a speed level, so the game FSM can shorten playback as rounds advance.

## Interface
- `MAX_LEN`, default 32: pattern memory depth in entries.
- `IDX_W`, default 5: address width; `2**IDX_W` must be at least `MAX_LEN`.
- `ON_CYCLES`, default 25_000_000: ON interval in `clk` cycles at speed 0.
- `GAP_CYCLES`, default 12_500_000: GAP interval in `clk` cycles at speed 0.
- `CNT_W`, default 27: interval counter width; must hold `ON_CYCLES` and `GAP_CYCLES`.

- `clk` input, 1: single clock for the whole block.
- `reset` input, 1: asynchronous, active-high reset.
- `start` input, 1: start request; sampled only in IDLE.
- `abort` input, 1: synchronous abort; highest priority after `reset`.
- `length` input, IDX_W+1: number of entries to play (0..MAX_LEN); latched at start.
- `speed` input, 2: scale level; durations are the base counts shifted right by `speed`; latched at start.
- `rd_addr` output, IDX_W: pattern memory read address.
- `rd_data` input, 2: color code from a registered memory; valid one cycle after `rd_addr` is presented.
- `led` output, 4: one-hot LED drive, `led = 1 << color` during ON, otherwise 0.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse on completion.

## Operation
- States: IDLE, FETCH, LOAD, ON, GAP, DONE.
- Latched at start:
  - `len_q = min(length, MAX_LEN)`.
  - `on_dur = max(ON_CYCLES >> speed, 1)`.
  - `gap_dur = max(GAP_CYCLES >> speed, 1)`.
- IDLE:
  - `start=1` and `len_q > 0`: `idx` is set to 0 and the FSM goes to FETCH.
  - `start=1` and `len_q = 0`: the FSM goes directly to DONE.
- FETCH: `rd_addr = idx`; go to LOAD.
- LOAD: capture `rd_data` into `color_q`, load `cnt = on_dur-1`, go to ON.
- ON: `led = onehot(color_q)`. Decrement `cnt`. At `cnt==0`, load `cnt = gap_dur-1` and go to GAP.
- GAP: `led = 0`. Decrement `cnt`. At `cnt==0`:
  - if `idx == len_q-1`, go to DONE;
  - otherwise increment `idx` and go to FETCH.
- DONE: `done=1` for this cycle only; go to IDLE.
- `rd_addr` is the registered `idx` and holds its value in IDLE.
- `start` is ignored outside IDLE. `length` and `speed` changes after the start cycle have no effect on the current playback.
- `abort=1` in any state moves the FSM to IDLE on the next edge:
  - `led` goes to 0;
  - no `done` pulse is issued;
  - `idx` and `cnt` are cleared.
- `abort` together with `start` in IDLE: `abort` wins and the FSM stays in IDLE.
- Reset values: state IDLE, `led=0`, `busy=0`, `done=0`, `rd_addr=0`, `cnt=0`, `color_q=0`.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Timing
- Start is sampled on edge E0. `busy` rises after E0 (FETCH occupies E0..E1).
- Per entry: 1 FETCH + 1 LOAD + `on_dur` ON + `gap_dur` GAP cycles.
- The first LED lights 2 cycles after the FSM leaves IDLE.
- Total from the first FETCH cycle to the DONE cycle: `len_q*(2+on_dur+gap_dur)` cycles, then 1 DONE cycle.
- `done` and `busy` are both high in the DONE cycle. `busy` is low the following cycle, and a new `start` can be accepted then.
- `length=0`: DONE is reached 1 cycle after start, with no memory reads and no LEDs lit.
- Speed shift: `>>3` with `ON_CYCLES < 8` clamps to 1 cycle; the counter never wraps.
- Reset asserted mid-ON: `led` clears asynchronously, with no `done` pulse.

## Test plan
- Bench parameters for all scenarios: `ON_CYCLES=8`, `GAP_CYCLES=4`, `MAX_LEN=32`, `IDX_W=5`.
1. Basic playback. Memory `{2,0,3}`, `length=3`, `speed=0`, start pulse → `led` shows 4'b0100, then 4'b0001, then 4'b1000, each for exactly 8 cycles with 4-cycle blanks between. `rd_addr` steps 0,1,2. `done` pulses 42 cycles after the first FETCH cycle, and `busy` falls the next cycle.
2. Speed scaling. Same pattern with `speed=2` → ON lasts 2 cycles, GAP lasts 1 cycle, 5 cycles per entry, `done` pulses after 15 cycles. With `speed=3` → ON lasts 1 cycle and GAP lasts 1 cycle (clamped).
3. Edge lengths:
   - `length=0` → `done` pulses 1 cycle after start, `led` stays 0, no memory reads.
   - `length=40` → clamped to 32 entries; `rd_addr` reaches 31 and never wraps.
4. Abort and ignored start. Assert `abort` during the ON phase of entry 1 → `led=0` and `busy=0` the next cycle, and `done` never pulses. A `start` asserted while busy, before the abort, is ignored: `idx` is unchanged.
5. Asynchronous reset mid-GAP. Assert `reset` between clock edges → all outputs go to their reset values immediately. After release, a new start (`length=1`) plays normally and `done` pulses after 14 cycles.
6. Back-to-back runs. Pulse `start` in the cycle immediately after `done`, with new `length` and `speed` values → the second run uses the new values and `rd_addr` restarts at 0.
